thread_issue_sequencer: RTL
===========================

# thread_issue_sequencer

Sequences one accepted instruction across all active threads of a block, producing the per-thread `thread_read` index for register-file operand reads and the matching `thread_write` index, delayed by the pipeline's writeback latency, for the write port. It sits directly upstream of the threaded register file and drives its `thread_read`, `thread_write` and write-enable qualification. It also stalls instruction fetch until every thread's result has been written back.

## Interface
- `NUM_THREADS`, 16: threads per block; legal range 1–16.
- `WB_LATENCY`, 3: cycles from operand read (issue) to register-file write; legal range 1–8.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_valid` input 1: a decoded instruction is available for sequencing.
- `instr_ready` output 1: sequencer is idle and accepts an instruction this cycle.
- `instr_writes` input 1: the accepted instruction writes a register (sampled at accept).
- `thread_mask` input `NUM_THREADS`: active-thread mask, sampled at accept; bit i set means thread i is active.
- `thread_read` output 5: thread index for the operand read this cycle.
- `issue_valid` output 1: `thread_read` is valid this cycle.
- `thread_write` output 5: thread index for the register-file write this cycle.
- `wb_valid` output 1: write qualifier; the register-file `WE3` is ANDed with it externally.
- `pc_stall` output 1: holds the PC; high whenever not IDLE.
- `instr_done` output 1: one-cycle pulse when the instruction is fully retired.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
- **IDLE**
  - `instr_ready`=1, `pc_stall`=0.
  - On `instr_valid`: latch mask and `instr_writes`, then go to ISSUE.
  - If the latched effective mask is zero, go to DRAIN instead with nothing in flight.
- **ISSUE**
  - Each cycle, `thread_read` equals the lowest-indexed remaining active thread, and `issue_valid`=1.
  - That thread's mask bit is cleared on the same edge.
  - After the last active thread issues, go to DRAIN.
- **DRAIN**
  - Wait until the writeback delay line is empty, then go to IDLE.
  - `instr_done` pulses in the final DRAIN cycle.
- **Writeback delay line**
  - A shift register of depth `WB_LATENCY` carries {index, valid}.
  - `thread_write` and `wb_valid` are its tail.
  - `wb_valid` = tail valid AND latched `instr_writes`.
- Indices are zero-extended to 5 bits; upper bits are 0 for `NUM_THREADS` ≤ 16.
- `instr_valid` while not IDLE is ignored. The upstream holds it until `instr_ready`.
- When idle, `thread_read` holds its last value and `issue_valid`=0. The register-file read is a don't-care in that case.

## Timing
- Reset values: state=IDLE, `instr_ready`=1, `issue_valid`=0, `wb_valid`=0, `thread_read`=0, `thread_write`=0, `pc_stall`=0, `instr_done`=0. The delay line is cleared.
- Accept happens in cycle A. The first `issue_valid` is in A+1. Issues for N active threads occupy A+1 through A+N.
- The write for the thread issued in cycle C appears in cycle C+`WB_LATENCY`.
- For N ≥ 1, `instr_done` is asserted in A+N+`WB_LATENCY`. `instr_ready` returns to 1 in A+N+`WB_LATENCY`+1.
- For a zero mask, `instr_done` is asserted in A+1 and `instr_ready`=1 in A+2.
- `pc_stall` is high from A+1 until `instr_done` inclusive.
- Reset asserted mid-instruction: all outputs take reset values immediately (asynchronous) and the in-flight instruction is discarded. `wb_valid` must be 0 while `rst_n`=0.
- Thread index NUM_THREADS−1 issues and retires normally; there is no wrap-around to 0 within one instruction.

## Configuration
- `THREAD_MASK_EN`
  - **Defined:** `thread_mask` is honoured; only active threads issue, and a zero mask retires immediately.
  - **Undefined:** `thread_mask` is ignored and the effective mask is all-ones. Every instruction issues threads 0..NUM_THREADS−1, so latency is always NUM_THREADS+`WB_LATENCY`.

## Test plan
- **Reset then full mask.** Apply reset, then accept with mask 0xFFFF and `instr_writes`=1.
  - `thread_read` reads 0..15 in A+1..A+16.
  - `thread_write` reads 0..15 with `wb_valid` in A+4..A+19.
  - `instr_done` is asserted at A+19.
- **Sparse mask** (`THREAD_MASK_EN`). Mask 0x8421.
  - Issues are 0, 5, 10, 15 in A+1..A+4.
  - Writes occur in A+4..A+7, and `instr_done` is asserted at A+7.
- **Zero mask** (`THREAD_MASK_EN`). Mask 0x0000.
  - There is no `issue_valid` and no `wb_valid`.
  - `instr_done` is asserted at A+1, and `instr_ready` is 1 at A+2.
- **Non-writing instruction.** `instr_writes`=0 with mask 0x0003.
  - Issues are 0 and 1, and `wb_valid` never rises.
  - `instr_done` is asserted at A+5.
- **Back-to-back.** Hold `instr_valid` high continuously.
  - The second accept occurs exactly one cycle after the first `instr_done`.
  - The `instr_valid` held during busy cycles is not double-accepted.
- **Mid-operation reset.** Drop `rst_n` at A+6 of a full-mask instruction.
  - `wb_valid`, `issue_valid` and `pc_stall` go to 0 immediately.
  - After release, `instr_ready`=1 and no stale writes emerge.

Source files
------------

// File: rtl/thread_issue_sequencer.sv
// Walks one accepted instruction across the active threads of a block, then
// waits for the writeback delay line to empty. Optional `THREAD_MASK_EN honours thread_mask.
module thread_issue_sequencer #(
  parameter int NUM_THREADS = 16,
  parameter int WB_LATENCY  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   instr_writes,
  input  logic [NUM_THREADS-1:0] thread_mask,
  output logic [4:0]             thread_read,
  output logic                   issue_valid,
  output logic [4:0]             thread_write,
  output logic                   wb_valid,
  output logic                   pc_stall,
  output logic                   instr_done
);

  // Handshake: an instruction is taken on a rising edge where instr_valid and
  // instr_ready are both high; upstream holds instr_valid until then.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                         state_q, state_d;
  logic [NUM_THREADS-1:0]         rem_q, rem_d;
  logic                           writes_q, writes_d;
  logic [4:0]                     thread_read_q, thread_read_d;
  logic                           issue_valid_q, issue_valid_d;
  logic [WB_LATENCY-1:0]          dl_v_q, dl_v_d;
  logic [WB_LATENCY-1:0][4:0]     dl_idx_q, dl_idx_d;

  logic [NUM_THREADS-1:0]         eff_mask;
  logic [NUM_THREADS-1:0]         pick_src;
  logic [NUM_THREADS-1:0]         low_clr;
  logic [4:0]                     low_idx;
  logic                           found;
  logic                           pipe_busy;

`ifdef THREAD_MASK_EN
  assign eff_mask = thread_mask;
`else
  assign eff_mask = thread_mask | {NUM_THREADS{1'b1}};
`endif

  // Lowest set bit of the mask being consumed, and that mask with the bit cleared.
  always_comb begin
    pick_src = (state_q == IDLE) ? eff_mask : rem_q;
    low_clr  = pick_src;
    low_idx  = 5'd0;
    found    = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (pick_src[i] && !found) begin
        low_clr[i] = 1'b0;
        low_idx    = 5'(i);
        found      = 1'b1;
      end
    end
  end

  // Everything ahead of the tail must be empty in the final DRAIN cycle.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < WB_LATENCY - 1; i++) begin
      pipe_busy = pipe_busy | dl_v_q[i];
    end
  end

  always_comb begin
    dl_v_d[0]   = issue_valid_q;
    dl_idx_d[0] = thread_read_q;
    for (int i = 1; i < WB_LATENCY; i++) begin
      dl_v_d[i]   = dl_v_q[i-1];
      dl_idx_d[i] = dl_idx_q[i-1];
    end
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    writes_d      = writes_q;
    thread_read_d = thread_read_q;
    issue_valid_d = issue_valid_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          writes_d = instr_writes;
          if (eff_mask == '0) begin
            rem_d   = '0;
            state_d = DRAIN;
          end else begin
            thread_read_d = low_idx;
            issue_valid_d = 1'b1;
            rem_d         = low_clr;
            state_d       = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rem_q != '0) begin
          thread_read_d = low_idx;
          issue_valid_d = 1'b1;
          rem_d         = low_clr;
        end else begin
          issue_valid_d = 1'b0;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      writes_q      <= 1'b0;
      thread_read_q <= 5'd0;
      issue_valid_q <= 1'b0;
      dl_v_q        <= '0;
      dl_idx_q      <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      writes_q      <= writes_d;
      thread_read_q <= thread_read_d;
      issue_valid_q <= issue_valid_d;
      dl_v_q        <= dl_v_d;
      dl_idx_q      <= dl_idx_d;
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign pc_stall     = (state_q != IDLE);
  assign instr_done   = (state_q == DRAIN) && !pipe_busy;
  assign thread_read  = thread_read_q;
  assign issue_valid  = issue_valid_q;
  assign thread_write = dl_idx_q[WB_LATENCY-1];
  assign wb_valid     = dl_v_q[WB_LATENCY-1] & writes_q;

endmodule
